// File: rtl/brush_pkg.sv
// brush_pkg: shared state encoding and constants for the material brush painter
package brush_pkg;
  typedef enum logic [1:0] {IDLE, PAINT, REARM} state_t;
  localparam int BRUSH_CNT_WIDTH = 4;
  localparam int MATERIAL_RESET = 1;
endpackage

// File: rtl/brush_cell_iterator.sv
// brush_cell_iterator: walks the brush square row-major, clips to screen, forms VRAM addresses
module brush_cell_iterator
  import brush_pkg::*;
#(
  parameter int COLUMNS    = 640,
  parameter int ROWS       = 400,
  parameter int ADDR_WIDTH = $clog2(COLUMNS * ROWS),
  parameter int XW         = $clog2(COLUMNS),
  parameter int YW         = $clog2(ROWS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [XW-1:0]              cx,
  input  logic [YW-1:0]              cy,
  input  logic [BRUSH_CNT_WIDTH-1:0] size,
  output logic                       cell_valid,
  output logic                       cell_in_bounds,
  output logic [ADDR_WIDTH-1:0]      cell_address,
  output logic                       last
);
  localparam logic [BRUSH_CNT_WIDTH-1:0] ONE = 1;
  localparam logic [XW:0] XLIM = COLUMNS[XW:0];
  localparam logic [YW:0] YLIM = ROWS[YW:0];
  localparam logic [ADDR_WIDTH-1:0] COLS_A = COLUMNS[ADDR_WIDTH-1:0];
  logic signed [XW:0] x0, x;
  logic signed [YW:0] y0, y;
  logic [BRUSH_CNT_WIDTH-1:0] s, dx, dy, sm1;
  logic [XW:0] half_x;
  logic [YW:0] half_y;
  logic [ADDR_WIDTH-1:0] xu, yu;
  assign half_x = {{(XW + 2 - BRUSH_CNT_WIDTH){1'b0}}, size[BRUSH_CNT_WIDTH-1:1]};
  assign half_y = {{(YW + 2 - BRUSH_CNT_WIDTH){1'b0}}, size[BRUSH_CNT_WIDTH-1:1]};
  assign sm1 = s - ONE;
  assign x = x0 + $signed({{(XW + 1 - BRUSH_CNT_WIDTH){1'b0}}, dx});
  assign y = y0 + $signed({{(YW + 1 - BRUSH_CNT_WIDTH){1'b0}}, dy});
  assign xu = {{(ADDR_WIDTH - XW){1'b0}}, x[XW-1:0]};
  assign yu = {{(ADDR_WIDTH - YW){1'b0}}, y[YW-1:0]};
  assign cell_in_bounds = !x[XW] && !y[YW] && $unsigned(x) < XLIM && $unsigned(y) < YLIM;
  assign cell_address = cell_in_bounds ? yu * COLS_A + xu : '0;
  assign last = cell_valid && dx == sm1 && dy == sm1;
  // latch origin and size on start, then step dx fastest until the far corner
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cell_valid <= 1'b0;
      x0 <= '0;
      y0 <= '0;
      s <= ONE;
      dx <= '0;
      dy <= '0;
    end else if (start) begin
      cell_valid <= 1'b1;
      x0 <= $signed({1'b0, cx}) - $signed(half_x);
      y0 <= $signed({1'b0, cy}) - $signed(half_y);
      s <= size;
      dx <= '0;
      dy <= '0;
    end else if (cell_valid) begin
      dx <= dx == sm1 ? '0 : dx + ONE;
      dy <= dx == sm1 ? dy + ONE : dy;
      cell_valid <= !last;
    end
endmodule

// File: rtl/material_brush_painter.sv
// material_brush_painter: square material brush stamping with VRAM write arbitration
module material_brush_painter
  import brush_pkg::*;
#(
  parameter int COLUMNS    = 640,
  parameter int ROWS       = 400,
  parameter int DATA_WIDTH = 2,
  parameter int BRUSH_MAX  = 7,
  parameter int ADDR_WIDTH = $clog2(COLUMNS * ROWS)
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        draw_en_i,
  input  logic                        type_next_i,
  input  logic                        size_up_i,
  input  logic                        size_down_i,
  input  logic [$clog2(COLUMNS)-1:0]  mouse_x_i,
  input  logic [$clog2(ROWS)-1:0]     mouse_y_i,
  input  logic [ADDR_WIDTH-1:0]       gst_wr_address_i,
  input  logic [DATA_WIDTH-1:0]       gst_wr_data_i,
  input  logic                        gst_wr_en_i,
  output logic                        gst_stall_o,
  output logic [ADDR_WIDTH-1:0]       vram_wr_address_o,
  output logic [DATA_WIDTH-1:0]       vram_wr_data_o,
  output logic                        vram_wr_en_o,
  output logic [DATA_WIDTH-1:0]       material_o,
  output logic [BRUSH_CNT_WIDTH-1:0]  brush_size_o,
  output logic                        busy_o
);
  localparam logic [BRUSH_CNT_WIDTH-1:0] SMAX = BRUSH_MAX[BRUSH_CNT_WIDTH-1:0];
  localparam logic [BRUSH_CNT_WIDTH-1:0] ONE = 1;
  state_t state;
  logic start, last, cell_valid, cell_in_bounds;
  logic [ADDR_WIDTH-1:0] cell_address;
  logic [DATA_WIDTH-1:0] mat_l;
  assign start = state == IDLE && draw_en_i;
  assign gst_stall_o = state != IDLE;
  assign busy_o = state != IDLE;
  brush_cell_iterator #(
    .COLUMNS(COLUMNS),
    .ROWS(ROWS),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_iter (
    .clk(clk_i),
    .rst_n(reset_i),
    .start(start),
    .cx(mouse_x_i),
    .cy(mouse_y_i),
    .size(brush_size_o),
    .cell_valid(cell_valid),
    .cell_in_bounds(cell_in_bounds),
    .cell_address(cell_address),
    .last(last)
  );
  // stroke sequencing: IDLE -> PAINT for S*S cells -> one REARM slot -> IDLE
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) state <= IDLE;
    else state <= start ? PAINT : (state == PAINT && last) ? REARM : state == REARM ? IDLE : state;
  // user-adjustable material (wrapping) and brush side (saturating)
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) begin
      material_o <= MATERIAL_RESET[DATA_WIDTH-1:0];
      brush_size_o <= ONE;
    end else begin
      material_o <= material_o + {{(DATA_WIDTH - 1){1'b0}}, type_next_i};
      brush_size_o <= (size_up_i && !size_down_i && brush_size_o < SMAX) ? brush_size_o + ONE :
                      (size_down_i && !size_up_i && brush_size_o > ONE) ? brush_size_o - ONE : brush_size_o;
    end
  // stroke keeps the material it started with
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) mat_l <= '0;
    else if (start) mat_l <= material_o;
  // registered VRAM port: game-state passthrough when idle, brush cells while painting
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) begin
      vram_wr_en_o <= 1'b0;
      vram_wr_address_o <= '0;
      vram_wr_data_o <= '0;
    end else begin
      vram_wr_en_o <= state == IDLE ? gst_wr_en_i : state == PAINT && cell_valid && cell_in_bounds;
      vram_wr_address_o <= state == IDLE ? gst_wr_address_i : cell_address;
      vram_wr_data_o <= state == IDLE ? gst_wr_data_i : mat_l;
    end
endmodule

// File: tb/tb_material_brush_painter.sv
// tb_material_brush_painter: scoreboarded bench for the material brush painter
module tb_material_brush_painter;
  localparam int COLUMNS = 640, ROWS = 400, DW = 2, AW = 18;
  logic clk = 0, reset_i = 0, draw_en_i = 0, type_next_i = 0, size_up_i = 0, size_down_i = 0;
  logic [9:0] mouse_x_i = 0;
  logic [8:0] mouse_y_i = 0;
  logic [AW-1:0] gst_wr_address_i = 0;
  logic [DW-1:0] gst_wr_data_i = 0;
  logic gst_wr_en_i = 0;
  logic gst_stall_o, vram_wr_en_o, busy_o;
  logic [AW-1:0] vram_wr_address_o;
  logic [DW-1:0] vram_wr_data_o, material_o;
  logic [3:0] brush_size_o;

  material_brush_painter dut (
    .clk_i(clk), .reset_i(reset_i), .draw_en_i(draw_en_i), .type_next_i(type_next_i),
    .size_up_i(size_up_i), .size_down_i(size_down_i), .mouse_x_i(mouse_x_i), .mouse_y_i(mouse_y_i),
    .gst_wr_address_i(gst_wr_address_i), .gst_wr_data_i(gst_wr_data_i), .gst_wr_en_i(gst_wr_en_i),
    .gst_stall_o(gst_stall_o), .vram_wr_address_o(vram_wr_address_o), .vram_wr_data_o(vram_wr_data_o),
    .vram_wr_en_o(vram_wr_en_o), .material_o(material_o), .brush_size_o(brush_size_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [AW-1:0] addr; logic [DW-1:0] data;} wr_t;
  typedef struct {logic tn; logic up; logic dn; int mat; int size;} vec_t;
  wr_t q[$];
  vec_t vt[9];
  int compared = 0, mismatched = 0;
  int m_mat = 1, m_size = 1, busy_left = 0;

  task automatic check(string name, int act, int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // scoreboard: every VRAM write must match the oldest expected write
  always @(negedge clk) begin
    wr_t e;
    if (reset_i && vram_wr_en_o) begin
      if (q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_write: got addr %0d data %0d expected no write", vram_wr_address_o, vram_wr_data_o);
      end else begin
        e = q.pop_front();
        check("wr_addr", int'(vram_wr_address_o), int'(e.addr));
        check("wr_data", int'(vram_wr_data_o), int'(e.data));
      end
    end
  end

  task automatic push_cells();
    int x, y;
    for (int dy = 0; dy < m_size; dy++)
      for (int dx = 0; dx < m_size; dx++) begin
        x = int'(mouse_x_i) - m_size / 2 + dx;
        y = int'(mouse_y_i) - m_size / 2 + dy;
        if (x >= 0 && x < COLUMNS && y >= 0 && y < ROWS)
          q.push_back('{AW'(y * COLUMNS + x), DW'(m_mat)});
      end
  endtask

  // one clock with model update; inputs are already driven
  task automatic step();
    check("stall", int'(gst_stall_o), int'(busy_left > 0));
    check("busy", int'(busy_o), int'(busy_left > 0));
    if (busy_left == 0 && gst_wr_en_i) q.push_back('{gst_wr_address_i, gst_wr_data_i});
    if (busy_left == 0 && draw_en_i) begin
      push_cells();
      busy_left = m_size * m_size + 1;
    end else if (busy_left > 0) busy_left--;
    if (type_next_i) m_mat = (m_mat + 1) % 4;
    if (size_up_i && !size_down_i && m_size < 7) m_size++;
    if (size_down_i && !size_up_i && m_size > 1) m_size--;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(logic tn, logic up, logic dn);
    type_next_i = tn;
    size_up_i = up;
    size_down_i = dn;
    step();
    type_next_i = 0;
    size_up_i = 0;
    size_down_i = 0;
  endtask

  task automatic stroke(int x, int y);
    mouse_x_i = 10'(x);
    mouse_y_i = 9'(y);
    draw_en_i = 1;
    step();
    draw_en_i = 0;
    for (int i = 0; i < 60 && busy_left > 0; i++) step();
    step();
    step();
    check("queue_drained", q.size(), 0);
  endtask

  initial begin
    vt[0] = '{1, 0, 0, 2, 1};
    vt[1] = '{1, 0, 0, 3, 1};
    vt[2] = '{1, 0, 0, 0, 1};
    vt[3] = '{0, 1, 0, 0, 2};
    vt[4] = '{0, 1, 1, 0, 2};
    vt[5] = '{0, 0, 1, 0, 1};
    vt[6] = '{0, 0, 1, 0, 1};
    vt[7] = '{0, 1, 1, 0, 1};
    vt[8] = '{1, 1, 0, 1, 2};
    repeat (3) @(posedge clk);
    #1;
    check("rst_en", int'(vram_wr_en_o), 0);
    check("rst_addr", int'(vram_wr_address_o), 0);
    check("rst_stall", int'(gst_stall_o), 0);
    check("rst_mat", int'(material_o), 1);
    check("rst_size", int'(brush_size_o), 1);
    reset_i = 1;
    // game-state passthrough
    gst_wr_address_i = 1234;
    gst_wr_data_i = 2;
    gst_wr_en_i = 1;
    step();
    gst_wr_en_i = 0;
    check("pass_addr", int'(vram_wr_address_o), 1234);
    check("pass_data", int'(vram_wr_data_o), 2);
    check("pass_en", int'(vram_wr_en_o), 1);
    step();
    // material and size register table
    for (int i = 0; i < 9; i++) begin
      pulse(vt[i].tn, vt[i].up, vt[i].dn);
      check("tbl_mat", int'(material_o), vt[i].mat);
      check("tbl_size", int'(brush_size_o), vt[i].size);
    end
    for (int i = 0; i < 10; i++) pulse(0, 1, 0);
    check("size_sat_hi", int'(brush_size_o), 7);
    for (int i = 0; i < 10; i++) pulse(0, 0, 1);
    check("size_sat_lo", int'(brush_size_o), 1);
    // size 3, material 2, centred stroke
    pulse(0, 1, 0);
    pulse(0, 1, 0);
    for (int i = 0; i < 4 && m_mat != 2; i++) pulse(1, 0, 0);
    check("pre_mat", int'(material_o), 2);
    check("pre_size", int'(brush_size_o), 3);
    stroke(10, 5);
    // corner clipping, with a material change mid-stroke
    mouse_x_i = 0;
    mouse_y_i = 0;
    draw_en_i = 1;
    step();
    draw_en_i = 0;
    step();
    pulse(1, 0, 0);
    for (int i = 0; i < 20 && busy_left > 0; i++) step();
    step();
    check("corner_drained", q.size(), 0);
    check("mid_mat", int'(material_o), 3);
    stroke(639, 399);
    // held draw at size 1 with continuous game-state writes
    for (int i = 0; i < 4 && m_size != 1; i++) pulse(0, 0, 1);
    mouse_x_i = 20;
    mouse_y_i = 30;
    gst_wr_en_i = 1;
    gst_wr_data_i = 1;
    draw_en_i = 1;
    for (int i = 0; i < 9; i++) begin
      gst_wr_address_i = AW'(100 + i);
      step();
    end
    draw_en_i = 0;
    gst_wr_en_i = 0;
    for (int i = 0; i < 10 && busy_left > 0; i++) step();
    step();
    step();
    check("held_drained", q.size(), 0);
    // reset in the middle of a stroke
    pulse(0, 1, 0);
    pulse(0, 1, 0);
    mouse_x_i = 100;
    mouse_y_i = 100;
    draw_en_i = 1;
    step();
    draw_en_i = 0;
    step();
    step();
    reset_i = 0;
    #1;
    check("mid_rst_en", int'(vram_wr_en_o), 0);
    check("mid_rst_stall", int'(gst_stall_o), 0);
    check("mid_rst_busy", int'(busy_o), 0);
    check("mid_rst_mat", int'(material_o), 1);
    check("mid_rst_size", int'(brush_size_o), 1);
    q.delete();
    busy_left = 0;
    m_mat = 1;
    m_size = 1;
    repeat (2) @(posedge clk);
    #1;
    reset_i = 1;
    for (int i = 0; i < 12; i++) step();
    check("post_rst_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
